hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage core. Consumes the decode-stage source selects together with the destination and control fields held in the ID/EX, EX/MEM and MEM/WB pipeline registers. Generates the `stall`, `nop`, `flush` and freeze controls that those registers and the fetch logic obey. Also owns halt sequencing, redirect-versus-icache-miss tracking, operand forwarding selects and a stall-cycle counter.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-low reset
- `read1RegSel_id`, `read2RegSel_id`  in  3 each  source register selects of the instruction in ID
- `read1Used_id`, `read2Used_id`  in  1 each  ID instruction actually reads that source
- `Write_register_ex`, `RegWrite_ex`, `MemRead_ex`  in  3/1/1  ID/EX destination, write enable and load flag
- `Write_register_mem`, `RegWrite_mem`, `MemRead_mem`  in  3/1/1  EX/MEM destination, write enable and load flag
- `Write_register_wb`, `RegWrite_wb`  in  3/1  MEM/WB destination and write enable
- `redirect_ex`  in  1  taken branch or jump resolved in EX this cycle
- `halt_ex`  in  1  HALT instruction is in EX
- `IC_Stall`, `DC_Stall`  in  1 each  instruction-cache and data-cache busy
- `stall`  out  1  hold PC and IF/ID
- `nop`  out  1  inject a bubble into ID/EX
- `flush`  out  1  kill the IF/ID contents
- `freeze`  out  1  hold every pipeline register (drives their `DC_Stall` pins)
- `halted`  out  1  core has halted
- `fwdA_sel`, `fwdB_sel`  out  2 each  EX operand source: 00 register file, 01 EX/MEM, 10 MEM/WB
- `stall_cycles`  out  16  saturating count of lost cycles

## Operation
- **State machine.** States are RUN, RDWAIT and HALTED. Reset, or `rst`=0 at any edge, forces RUN and `stall_cycles`=0.
- **`freeze`.** `freeze` = `DC_Stall` in every state. While `freeze`=1:
  - state is held;
  - `stall`=1, `nop`=0, `flush`=0;
  - `stall_cycles` still counts.
- **Source match.** `match(x)` = (used source select == `Write_register_x`) & `RegWrite_x`. `hazard` is asserted if either used source matches; the rule depends on the configuration.
- **RUN priority, highest first:**
  1. `redirect_ex`: `flush`=1 and `nop`=1. If `IC_Stall`=1 in the same cycle, go to RDWAIT.
  2. `halt_ex`: go to HALTED. `stall`=1 and `nop`=1 this cycle.
  3. `hazard`: `stall`=1 and `nop`=1.
  4. `IC_Stall`: `stall`=1 and `nop`=1.
  5. Otherwise all three outputs are 0.
- **RDWAIT.** `flush`=1, `nop`=1 and `stall`=0 every cycle. Return to RUN on the first cycle `IC_Stall`=0; that cycle still flushes.
- **HALTED.** `stall`=1 and `nop`=1 permanently. `halted`=1. Only reset leaves this state. Older instructions in MEM and WB drain normally.
- **`stall_cycles`.** Increments in RUN or RDWAIT on any cycle where `stall`, `flush` or `freeze` is 1. Saturates at 16'hFFFF and does not count in HALTED.
- **Register R0.** R0 is an ordinary register and is not excluded from matching.

## Timing
- `stall`, `nop`, `flush`, `freeze` and `fwd*_sel` are combinational from the inputs and the current state, valid in the same cycle. They must not depend combinationally on one another.
- `halted` and `stall_cycles` are registered. `halted` rises one cycle after `halt_ex` is accepted.
- **Reset values:** state RUN, `halted`=0, `stall_cycles`=0. During reset the combinational outputs follow the RUN equations.
- **`halt_ex` with `redirect_ex`:** redirect wins and `halt_ex` is ignored, because it is a wrong-path instruction.
- **`halt_ex` with `DC_Stall`:** the transition waits until `DC_Stall`=0.
- **`redirect_ex` with `DC_Stall`:** no action that cycle. The redirect is re-evaluated when the freeze releases, since ID/EX holds its value.
- **Load-use bubble (forwarding build):** exactly one cycle. The next cycle the load is in MEM, the condition clears, and the consumer later forwards from MEM/WB.

## Configuration
Macro `HAZARD_FWD_EN` selects the forwarding rule.
- **Defined:**
  - `hazard` = `MemRead_ex` & `match(ex)`.
  - `fwdX_sel` = 01 if `match(mem)` & ~`MemRead_mem`, else 10 if `match(wb)`, else 00. EX/MEM has priority over MEM/WB.
- **Undefined:**
  - `hazard` = `match(ex)` | `match(mem)`. The register file bypasses WB internally.
  - `fwdA_sel` and `fwdB_sel` are tied to 00.

## Test plan
- **Load-use.** LD R3 in EX (`MemRead_ex`=1, `Write_register_ex`=3) with an ID instruction reading R3 → with `HAZARD_FWD_EN`:
  - `stall`=1 and `nop`=1 for 1 cycle;
  - next cycle `stall`=0;
  - two cycles later `fwdA_sel`=10.
- **ALU dependence.** ADD writing R2 in EX with ID reading R2 →
  - with `HAZARD_FWD_EN`: `stall`=0, then `fwdA_sel`=01;
  - without it: `stall`=1 for 2 cycles.
- **Redirect during icache miss.** `redirect_ex`=1 with `IC_Stall`=1 for 3 cycles →
  - `flush`=1 on 4 consecutive cycles;
  - state returns to RUN;
  - `stall_cycles` advances by 4.
- **Freeze.** `DC_Stall`=1 for 5 cycles during RDWAIT →
  - `freeze`=1, `flush`=0, state held;
  - after release, RDWAIT resumes.
- **Halt.** `halt_ex`=1 →
  - `halted`=1 next cycle, `stall`=1 and `nop`=1 forever;
  - `stall_cycles` frozen;
  - `rst`=0 returns all outputs to reset values.
- **Counter saturation.** Force 70000 consecutive stall cycles → `stall_cycles` holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline registers and hazard_ctrl. The pipeline side
// (master) presents decode selects and stage destination/control fields and
// receives the stall/flush/forwarding controls. hazard_ctrl is the slave.
interface hazard_ctrl_if;
    // Decode-stage sources
    logic [2:0]  read1RegSel_id;
    logic [2:0]  read2RegSel_id;
    logic        read1Used_id;
    logic        read2Used_id;
    // ID/EX, EX/MEM, MEM/WB destination and control fields
    logic [2:0]  Write_register_ex;
    logic        RegWrite_ex;
    logic        MemRead_ex;
    logic [2:0]  Write_register_mem;
    logic        RegWrite_mem;
    logic        MemRead_mem;
    logic [2:0]  Write_register_wb;
    logic        RegWrite_wb;
    // Control-flow and memory-system events
    logic        redirect_ex;
    logic        halt_ex;
    logic        IC_Stall;
    logic        DC_Stall;
    // Controls back to the pipeline
    logic        stall;
    logic        nop;
    logic        flush;
    logic        freeze;
    logic        halted;
    logic [1:0]  fwdA_sel;
    logic [1:0]  fwdB_sel;
    logic [15:0] stall_cycles;

    modport master (
        output read1RegSel_id, read2RegSel_id, read1Used_id, read2Used_id,
        output Write_register_ex, RegWrite_ex, MemRead_ex,
        output Write_register_mem, RegWrite_mem, MemRead_mem,
        output Write_register_wb, RegWrite_wb,
        output redirect_ex, halt_ex, IC_Stall, DC_Stall,
        input  stall, nop, flush, freeze, halted, fwdA_sel, fwdB_sel, stall_cycles
    );

    modport slave (
        input  read1RegSel_id, read2RegSel_id, read1Used_id, read2Used_id,
        input  Write_register_ex, RegWrite_ex, MemRead_ex,
        input  Write_register_mem, RegWrite_mem, MemRead_mem,
        input  Write_register_wb, RegWrite_wb,
        input  redirect_ex, halt_ex, IC_Stall, DC_Stall,
        output stall, nop, flush, freeze, halted, fwdA_sel, fwdB_sel, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard/stall controller for the 5-stage core.
// Generates stall/nop/flush/freeze, sequences HALT, tracks a redirect that
// collides with an icache miss, selects EX operand forwarding and counts
// lost cycles. Optional macro HAZARD_FWD_EN enables operand forwarding;
// without it, any dependence on EX or MEM stalls until the writer reaches WB.
module hazard_ctrl (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, RDWAIT, HALTED} state_t;

    state_t      state_reg;
    state_t      state_next;
    state_t      cur_state;
    logic        halted_reg;
    logic [15:0] cnt_reg;

    logic        stall_c;
    logic        nop_c;
    logic        flush_c;
    logic        hazard;

    logic [2:0]  src_sel [2];
    logic [1:0]  src_used;
    logic [1:0]  match_ex;
    logic [1:0]  match_mem;
    logic [1:0]  match_wb;
    logic [1:0]  fwd_sel [2];

    assign src_sel[0]  = bus.read1RegSel_id;
    assign src_sel[1]  = bus.read2RegSel_id;
    assign src_used[0] = bus.read1Used_id;
    assign src_used[1] = bus.read2Used_id;

    // While reset is held the outputs behave as in RUN regardless of state.
    assign cur_state = rst ? state_reg : RUN;

    // Per-source match against each later stage, and the forwarding select.
    // R0 is a normal register here, so no zero-register exclusion.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign match_ex[gi]  = src_used[gi] && (src_sel[gi] == bus.Write_register_ex)  && bus.RegWrite_ex;
            assign match_mem[gi] = src_used[gi] && (src_sel[gi] == bus.Write_register_mem) && bus.RegWrite_mem;
            assign match_wb[gi]  = src_used[gi] && (src_sel[gi] == bus.Write_register_wb)  && bus.RegWrite_wb;
`ifdef HAZARD_FWD_EN
            // A load in EX/MEM has no data yet, so it cannot be the source.
            assign fwd_sel[gi] = (match_mem[gi] && !bus.MemRead_mem) ? 2'b01 :
                                 match_wb[gi]                        ? 2'b10 : 2'b00;
`else
            assign fwd_sel[gi] = 2'b00;
`endif
        end
    endgenerate

`ifdef HAZARD_FWD_EN
    // Only a load-use pair needs a bubble; everything else forwards.
    assign hazard = bus.MemRead_ex && (|match_ex);
`else
    // No forwarding: wait until the writer reaches WB (register file bypasses WB).
    assign hazard = (|match_ex) || (|match_mem);
    logic unused_nofwd;
    assign unused_nofwd = ^{bus.MemRead_ex, bus.MemRead_mem, match_wb};
`endif

    // Next-state and pipeline control decode; freeze overrides every state.
    always_comb begin
        stall_c    = 1'b0;
        nop_c      = 1'b0;
        flush_c    = 1'b0;
        state_next = cur_state;
        if (bus.DC_Stall) begin
            stall_c = 1'b1;
        end else begin
            case (cur_state)
                RUN: begin
                    if (bus.redirect_ex) begin
                        flush_c = 1'b1;
                        nop_c   = 1'b1;
                        if (bus.IC_Stall) state_next = RDWAIT;
                    end else if (bus.halt_ex) begin
                        stall_c    = 1'b1;
                        nop_c      = 1'b1;
                        state_next = HALTED;
                    end else if (hazard || bus.IC_Stall) begin
                        stall_c = 1'b1;
                        nop_c   = 1'b1;
                    end
                end
                RDWAIT: begin
                    flush_c = 1'b1;
                    nop_c   = 1'b1;
                    if (!bus.IC_Stall) state_next = RUN;
                end
                HALTED: begin
                    stall_c = 1'b1;
                    nop_c   = 1'b1;
                end
                default: state_next = RUN;
            endcase
        end
    end

    // State, registered halt flag and saturating lost-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= RUN;
            halted_reg <= 1'b0;
            cnt_reg    <= 16'd0;
        end else begin
            state_reg  <= state_next;
            halted_reg <= (state_next == HALTED);
            if ((cur_state != HALTED) && (stall_c || flush_c || bus.DC_Stall) &&
                (cnt_reg != 16'hFFFF))
                cnt_reg <= cnt_reg + 16'd1;
        end
    end

    assign bus.stall        = stall_c;
    assign bus.nop          = nop_c;
    assign bus.flush        = flush_c;
    assign bus.freeze       = bus.DC_Stall;
    assign bus.halted       = halted_reg;
    assign bus.stall_cycles = cnt_reg;
    assign bus.fwdA_sel     = fwd_sel[0];
    assign bus.fwdB_sel     = fwd_sel[1];
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations adapt to HAZARD_FWD_EN.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_idle();
        bus.read1RegSel_id     = 3'd0;
        bus.read2RegSel_id     = 3'd0;
        bus.read1Used_id       = 1'b0;
        bus.read2Used_id       = 1'b0;
        bus.Write_register_ex  = 3'd0;
        bus.RegWrite_ex        = 1'b0;
        bus.MemRead_ex         = 1'b0;
        bus.Write_register_mem = 3'd0;
        bus.RegWrite_mem       = 1'b0;
        bus.MemRead_mem        = 1'b0;
        bus.Write_register_wb  = 3'd0;
        bus.RegWrite_wb        = 1'b0;
        bus.redirect_ex        = 1'b0;
        bus.halt_ex            = 1'b0;
        bus.IC_Stall           = 1'b0;
        bus.DC_Stall           = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_idle();
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        set_idle();
        rst = 1'b0;
        tick();
        tick();
        settle();
        chk("rst_halted", {15'd0, bus.halted}, 16'd0);
        chk("rst_cnt", bus.stall_cycles, 16'd0);
        chk("rst_stall", {15'd0, bus.stall}, 16'd0);
        chk("rst_flush", {15'd0, bus.flush}, 16'd0);
        bus.IC_Stall = 1'b1;
        settle();
        chk("rst_ic_stall", {15'd0, bus.stall}, 16'd1);
        chk("rst_ic_nop", {15'd0, bus.nop}, 16'd1);
        tick();
        chk("rst_cnt_hold", bus.stall_cycles, 16'd0);

        // ---------------- ALU dependence on R2 ----------------
        do_reset();
        bus.read1Used_id = 1'b1; bus.read1RegSel_id = 3'd2;
        bus.Write_register_ex = 3'd2; bus.RegWrite_ex = 1'b1;
        settle();
`ifdef HAZARD_FWD_EN
        chk("alu1_stall", {15'd0, bus.stall}, 16'd0);
        chk("alu1_fwdA", {14'd0, bus.fwdA_sel}, 16'd0);
        tick();
        bus.RegWrite_ex = 1'b0;
        bus.Write_register_mem = 3'd2; bus.RegWrite_mem = 1'b1;
        bus.Write_register_wb = 3'd2; bus.RegWrite_wb = 1'b1;
        settle();
        chk("alu2_stall", {15'd0, bus.stall}, 16'd0);
        chk("alu2_fwdA_pri", {14'd0, bus.fwdA_sel}, 16'd1);
        tick();
        bus.RegWrite_mem = 1'b0;
        settle();
        chk("alu3_fwdA_wb", {14'd0, bus.fwdA_sel}, 16'd2);
        tick();
        chk("alu_cnt", bus.stall_cycles, 16'd0);
`else
        chk("alu1_stall", {15'd1, bus.stall}, 16'd3);
        chk("alu1_nop", {15'd0, bus.nop}, 16'd1);
        tick();
        bus.RegWrite_ex = 1'b0;
        bus.Write_register_mem = 3'd2; bus.RegWrite_mem = 1'b1;
        settle();
        chk("alu2_stall", {15'd0, bus.stall}, 16'd1);
        tick();
        bus.RegWrite_mem = 1'b0;
        bus.Write_register_wb = 3'd2; bus.RegWrite_wb = 1'b1;
        settle();
        chk("alu3_stall", {15'd0, bus.stall}, 16'd0);
        chk("alu3_fwdA", {14'd0, bus.fwdA_sel}, 16'd0);
        tick();
        chk("alu_cnt", bus.stall_cycles, 16'd2);
`endif

        // ---------------- load-use on R3, second source, R0 ----------------
        do_reset();
        bus.read1Used_id = 1'b1; bus.read1RegSel_id = 3'd3;
        bus.Write_register_ex = 3'd3; bus.RegWrite_ex = 1'b1; bus.MemRead_ex = 1'b1;
        settle();
        chk("ld1_stall", {15'd0, bus.stall}, 16'd1);
        chk("ld1_nop", {15'd0, bus.nop}, 16'd1);
        tick();
        bus.RegWrite_ex = 1'b0; bus.MemRead_ex = 1'b0;
        bus.Write_register_mem = 3'd3; bus.RegWrite_mem = 1'b1; bus.MemRead_mem = 1'b1;
        settle();
`ifdef HAZARD_FWD_EN
        chk("ld2_stall", {15'd0, bus.stall}, 16'd0);
        chk("ld2_fwdA", {14'd0, bus.fwdA_sel}, 16'd0);
`else
        chk("ld2_stall", {15'd0, bus.stall}, 16'd1);
`endif
        tick();
        bus.RegWrite_mem = 1'b0; bus.MemRead_mem = 1'b0;
        bus.Write_register_wb = 3'd3; bus.RegWrite_wb = 1'b1;
        settle();
        chk("ld3_stall", {15'd0, bus.stall}, 16'd0);
`ifdef HAZARD_FWD_EN
        chk("ld3_fwdA", {14'd0, bus.fwdA_sel}, 16'd2);
`else
        chk("ld3_fwdA", {14'd0, bus.fwdA_sel}, 16'd0);
`endif
        tick();
        set_idle();
        bus.read2Used_id = 1'b1; bus.read2RegSel_id = 3'd5;
        bus.Write_register_mem = 3'd5; bus.RegWrite_mem = 1'b1;
        settle();
`ifdef HAZARD_FWD_EN
        chk("srcB_fwdB", {14'd0, bus.fwdB_sel}, 16'd1);
        chk("srcB_fwdA", {14'd0, bus.fwdA_sel}, 16'd0);
`else
        chk("srcB_stall", {15'd0, bus.stall}, 16'd1);
`endif
        bus.read2Used_id = 1'b0;
        settle();
        chk("unused_stall", {15'd0, bus.stall}, 16'd0);
        chk("unused_fwdB", {14'd0, bus.fwdB_sel}, 16'd0);
        set_idle();
        bus.read1Used_id = 1'b1; bus.read1RegSel_id = 3'd0;
        bus.Write_register_ex = 3'd0; bus.RegWrite_ex = 1'b1; bus.MemRead_ex = 1'b1;
        settle();
        chk("r0_stall", {15'd0, bus.stall}, 16'd1);
        tick();

        // ---------------- redirect during icache miss ----------------
        do_reset();
        bus.redirect_ex = 1'b1; bus.IC_Stall = 1'b1;
        settle();
        chk("rd1_flush", {15'd0, bus.flush}, 16'd1);
        chk("rd1_stall", {15'd0, bus.stall}, 16'd0);
        tick();
        bus.redirect_ex = 1'b0;
        settle();
        chk("rd2_flush", {15'd0, bus.flush}, 16'd1);
        chk("rd2_stall", {15'd0, bus.stall}, 16'd0);
        tick();
        settle();
        chk("rd3_flush", {15'd0, bus.flush}, 16'd1);
        tick();
        bus.IC_Stall = 1'b0;
        settle();
        chk("rd4_flush", {15'd0, bus.flush}, 16'd1);
        tick();
        chk("rd_cnt", bus.stall_cycles, 16'd4);
        settle();
        chk("rd_run_flush", {15'd0, bus.flush}, 16'd0);

        // ---------------- freeze during RDWAIT ----------------
        do_reset();
        bus.redirect_ex = 1'b1; bus.IC_Stall = 1'b1; bus.DC_Stall = 1'b1;
        settle();
        chk("fz0_flush", {15'd0, bus.flush}, 16'd0);
        chk("fz0_freeze", {15'd0, bus.freeze}, 16'd1);
        tick();
        bus.DC_Stall = 1'b0;
        settle();
        chk("fz1_flush", {15'd0, bus.flush}, 16'd1);
        tick();
        bus.redirect_ex = 1'b0; bus.IC_Stall = 1'b0; bus.DC_Stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("fz_freeze", {15'd0, bus.freeze}, 16'd1);
            chk("fz_flush", {15'd0, bus.flush}, 16'd0);
            chk("fz_stall", {15'd0, bus.stall}, 16'd1);
            chk("fz_nop", {15'd0, bus.nop}, 16'd0);
            tick();
        end
        bus.DC_Stall = 1'b0; bus.IC_Stall = 1'b1;
        settle();
        chk("fz_resume", {15'd0, bus.flush}, 16'd1);
        chk("fz_res_stall", {15'd0, bus.stall}, 16'd0);
        tick();
        bus.IC_Stall = 1'b0;
        settle();
        chk("fz_exit_flush", {15'd0, bus.flush}, 16'd1);
        tick();
        settle();
        chk("fz_run_flush", {15'd0, bus.flush}, 16'd0);
        tick();
        chk("fz_cnt", bus.stall_cycles, 16'd9);

        // ---------------- halt ----------------
        do_reset();
        bus.halt_ex = 1'b1; bus.DC_Stall = 1'b1;
        settle();
        chk("h0_nop", {15'd0, bus.nop}, 16'd0);
        tick();
        chk("h0_halted", {15'd0, bus.halted}, 16'd0);
        bus.DC_Stall = 1'b0;
        settle();
        chk("h1_stall", {15'd0, bus.stall}, 16'd1);
        chk("h1_nop", {15'd0, bus.nop}, 16'd1);
        tick();
        chk("h1_halted", {15'd0, bus.halted}, 16'd1);
        chk("h1_cnt", bus.stall_cycles, 16'd2);
        bus.halt_ex = 1'b0;
        bus.redirect_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("hl_stall", {15'd0, bus.stall}, 16'd1);
            chk("hl_nop", {15'd0, bus.nop}, 16'd1);
            chk("hl_flush", {15'd0, bus.flush}, 16'd0);
            tick();
        end
        chk("hl_halted", {15'd0, bus.halted}, 16'd1);
        chk("hl_cnt", bus.stall_cycles, 16'd2);
        rst = 1'b0;
        set_idle();
        settle();
        chk("hr_stall", {15'd0, bus.stall}, 16'd0);
        tick();
        chk("hr_halted", {15'd0, bus.halted}, 16'd0);
        chk("hr_cnt", bus.stall_cycles, 16'd0);
        rst = 1'b1;

        // halt behind a redirect is a wrong-path instruction
        do_reset();
        bus.redirect_ex = 1'b1; bus.halt_ex = 1'b1;
        settle();
        chk("hrd_flush", {15'd0, bus.flush}, 16'd1);
        chk("hrd_stall", {15'd0, bus.stall}, 16'd0);
        tick();
        set_idle();
        settle();
        chk("hrd_halted", {15'd0, bus.halted}, 16'd0);
        chk("hrd_run", {15'd0, bus.stall}, 16'd0);

        // ---------------- counter saturation ----------------
        do_reset();
        bus.IC_Stall = 1'b1;
        repeat (65534) tick();
        chk("sat_fffe", bus.stall_cycles, 16'hFFFE);
        tick();
        chk("sat_ffff", bus.stall_cycles, 16'hFFFF);
        repeat (4465) tick();
        chk("sat_hold", bus.stall_cycles, 16'hFFFF);
        chk("sat_stall", {15'd0, bus.stall}, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
